// File: rtl/db15_serial_reader.sv
// Serial reader for the DB15 arcade-stick adapter: scans a 74HC165 chain and
// presents two 16-bit active-high joystick words, updated atomically once per frame.
module db15_serial_reader #(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_valid,
  output logic        frame_strobe
);

  // state   | meaning
  // S_LOAD  | JOY_LOAD low for two ticks, chain captures the buttons
  // S_SHIFT | 32 bits, two ticks each: sample + JOY_CLK low, then JOY_CLK high
  // S_LATCH | single clk, raw frame copied to the joystick outputs
  // S_GAP   | idle for GAP_TICKS ticks before the next load

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [4:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      raw_q, raw_d;
  logic             sync1_q, sync2_q;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic [15:0]      joy1_q, joy1_d;
  logic [15:0]      joy2_q, joy2_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    raw_d      = raw_q;
    joy_clk_d  = joy_clk_q;
    joy_load_d = joy_load_q;
    joy1_d     = joy1_q;
    joy2_d     = joy2_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;

    case (state_q)
      S_LOAD: begin
        joy_load_d = 1'b0;
        joy_clk_d  = 1'b1;
        if (tick) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            joy_load_d = 1'b1;
            bit_d      = '0;
            phase_d    = 1'b0;
            state_d    = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (tick) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            // chain drives active-low buttons; store active-high, MSB first
            raw_d[5'd31 - bit_q] = ~sync2_q;
            joy_clk_d            = 1'b0;
          end else begin
            joy_clk_d = 1'b1;
            bit_d     = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_d = S_LATCH;
            end
          end
        end
      end

      S_LATCH: begin
        joy1_d   = raw_q[31:16];
        joy2_d   = raw_q[15:0];
        strobe_d = 1'b1;
        valid_d  = 1'b1;
        gap_d    = '0;
        state_d  = S_GAP;
      end

      S_GAP: begin
        joy_clk_d  = 1'b1;
        joy_load_d = 1'b1;
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            phase_d = 1'b0;
            state_d = S_LOAD;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      gap_q      <= '0;
      raw_q      <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
      joy1_q     <= '0;
      joy2_q     <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      raw_q      <= raw_d;
      sync1_q    <= JOY_DATA;
      sync2_q    <= sync1_q;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
    end
  end

  assign JOY_CLK      = joy_clk_q;
  assign JOY_LOAD     = joy_load_q;
  assign joystick1    = joy1_q;
  assign joystick2    = joy2_q;
  assign frame_valid  = valid_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: two instances (24/20 and 4/1) each scanning a
// 74HC165 chain model; a scoreboard checks every latched frame.
module tb_db15_serial_reader;

  localparam int DIV_A = 24;
  localparam int GAP_A = 20;
  localparam int DIV_B = 4;
  localparam int GAP_B = 1;

  logic        clk;
  logic        rst      [2];
  logic        joy_data [2];
  logic        joy_clk  [2];
  logic        joy_load [2];
  logic [15:0] j1       [2];
  logic [15:0] j2       [2];
  logic        fv       [2];
  logic        strobe   [2];
  logic [31:0] pat      [2];
  logic [31:0] exp_q    [$];
  logic [31:0] got_exp;
  logic [31:0] jp       [2];
  logic        rp       [2];
  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  db15_serial_reader #(.CLK_DIV(DIV_A), .GAP_TICKS(GAP_A)) u_dut_a (
    .clk(clk), .reset(rst[0]), .JOY_DATA(joy_data[0]), .JOY_CLK(joy_clk[0]),
    .JOY_LOAD(joy_load[0]), .joystick1(j1[0]), .joystick2(j2[0]),
    .frame_valid(fv[0]), .frame_strobe(strobe[0])
  );

  db15_serial_reader #(.CLK_DIV(DIV_B), .GAP_TICKS(GAP_B)) u_dut_b (
    .clk(clk), .reset(rst[1]), .JOY_DATA(joy_data[1]), .JOY_CLK(joy_clk[1]),
    .JOY_LOAD(joy_load[1]), .joystick1(j1[1]), .joystick2(j2[1]),
    .frame_valid(fv[1]), .frame_strobe(strobe[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chain model plus waveform timing checks, one per instance
  for (genvar g = 0; g < 2; g++) begin : gen_chain
    localparam int DIV    = (g == 0) ? DIV_A : DIV_B;
    localparam int GAPT   = (g == 0) ? GAP_A : GAP_B;
    localparam int PERIOD = (66 + GAPT) * DIV;
    logic [31:0] sr = '1;
    int   edges = 0, run = 0, prd = 0;
    logic started = 1'b0, hi_ok = 1'b0, pstart = 1'b0, pclk = 1'b1, pload = 1'b1;

    always @(negedge joy_load[g] or posedge joy_clk[g]) begin
      if (!joy_load[g]) sr <= ~pat[g];
      else              sr <= {sr[30:0], 1'b1};
    end
    assign joy_data[g] = sr[31];

    always @(negedge clk) begin
      if (rst[g] !== 1'b0) begin
        started = 1'b0; hi_ok = 1'b0; pstart = 1'b0;
        run = 0; edges = 0; prd = 0;
      end else begin
        run++;
        prd++;
        if (joy_load[g] === 1'b0) begin
          checks++;
          if (joy_clk[g] !== 1'b1) begin
            errors++;
            $display("FAIL load_while_clk_low: dut%0d JOY_CLK=%b while JOY_LOAD low, required 1", g, joy_clk[g]);
          end
        end
        if (joy_clk[g] && !pclk) begin
          if (joy_load[g]) edges++;
          checks++;
          if (run != DIV) begin
            errors++;
            $display("FAIL clk_low_time: dut%0d got %0d clk, required %0d", g, run, DIV);
          end
          run = 0;
          hi_ok = 1'b1;
        end else if (!joy_clk[g] && pclk) begin
          if (hi_ok) begin
            checks++;
            if (run != DIV) begin
              errors++;
              $display("FAIL clk_high_time: dut%0d got %0d clk, required %0d", g, run, DIV);
            end
          end
          run = 0;
        end
        if (!joy_load[g] && pload) begin
          hi_ok = 1'b0;
          if (pstart) begin
            checks++;
            if (prd < PERIOD - DIV || prd > PERIOD + DIV) begin
              errors++;
              $display("FAIL frame_period: dut%0d got %0d clk, required %0d +- %0d", g, prd, PERIOD, DIV);
            end
          end
          pstart = 1'b1;
          prd = 0;
        end
        if (joy_load[g] && !pload) begin
          if (started) begin
            checks++;
            if (edges != 32) begin
              errors++;
              $display("FAIL clk_edges_per_frame: dut%0d got %0d, required 32", g, edges);
            end
          end
          started = 1'b1;
          edges = 0;
        end
      end
      pclk  = joy_clk[g];
      pload = joy_load[g];
    end
  end

  // scoreboard monitor: pops one expected frame per strobe, flags any tearing
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (strobe[d] === 1'b1) begin
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: dut%0d presented %h, nothing expected", d, {j1[d], j2[d]});
        end else begin
          got_exp = exp_q.pop_front();
          if ({j1[d], j2[d]} !== got_exp || fv[d] !== 1'b1) begin
            errors++;
            $display("FAIL frame_words: dut%0d got %h valid=%b, required %h valid=1",
                     d, {j1[d], j2[d]}, fv[d], got_exp);
          end
        end
      end
      if (rst[d] === 1'b0 && rp[d] === 1'b0 && {j1[d], j2[d]} !== jp[d]) begin
        checks++;
        if (strobe[d] !== 1'b1) begin
          errors++;
          $display("FAIL output_tearing: dut%0d changed %h -> %h without strobe", d, jp[d], {j1[d], j2[d]});
        end
      end
      jp[d] = {j1[d], j2[d]};
      rp[d] = rst[d];
    end
  end

  function automatic int div_of(int d);
    return (d == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int budget_of(int d);
    return 2 * (66 + ((d == 0) ? GAP_A : GAP_B)) * div_of(d) + 50;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name, int d);
    checks++;
    errors++;
    $display("FAIL %s: dut%0d timed out after %0d clk", name, d, budget_of(d));
  endtask

  task automatic wait_load(int d, logic lvl, string name);
    int n;
    n = 0;
    while (joy_load[d] !== lvl && n < budget_of(d)) begin
      @(negedge clk);
      n++;
    end
    if (joy_load[d] !== lvl) timeout(name, d);
  endtask

  task automatic wait_clk_rises(int d, int count, string name);
    int seen, n;
    logic prev;
    seen = 0;
    n = 0;
    prev = joy_clk[d];
    while (seen < count && n < budget_of(d)) begin
      @(negedge clk);
      n++;
      if (joy_clk[d] && !prev) seen++;
      prev = joy_clk[d];
    end
    if (seen < count) timeout(name, d);
  endtask

  task automatic wait_strobe(int d, string name);
    int target, n;
    target = strobe_cnt + 1;
    n = 0;
    while (strobe_cnt < target && n < budget_of(d)) begin
      @(negedge clk);
      n++;
    end
    if (strobe_cnt < target) timeout(name, d);
  endtask

  task automatic run_suite(int d);
    int n, base;
    logic [31:0] p_old, p_new, p_rst;
    p_old = {16'h8421, 16'h0C03};
    p_new = {16'hA5F0, 16'h0FF1};
    p_rst = {16'h5A3C, 16'hC3A5};

    // reset held 10 clk
    rst[d] = 1'b1;
    pat[d] = 32'h0;
    repeat (10) @(negedge clk);
    check("reset_joy_clk", {31'h0, joy_clk[d]}, 32'h1);
    check("reset_joy_load", {31'h0, joy_load[d]}, 32'h1);
    check("reset_joysticks", {j1[d], j2[d]}, 32'h0);
    check("reset_frame_valid", {31'h0, fv[d]}, 32'h0);
    check("reset_frame_strobe", {31'h0, strobe[d]}, 32'h0);

    base = strobe_cnt;
    exp_q.push_back(32'h0);
    rst[d] = 1'b0;
    n = 0;
    while (joy_load[d] !== 1'b0 && n < 4 * div_of(d)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(n >= 1 && n <= div_of(d))) begin
      errors++;
      $display("FAIL load_fall_latency: dut%0d got %0d clk, required 1..%0d", d, n, div_of(d));
    end

    // frame 1: everything released
    wait_strobe(d, "frame1_strobe");
    pat[d] = p_old;
    exp_q.push_back(p_old);
    wait_load(d, 1'b0, "frame2_load");
    check("single_strobe_frame1", 32'(strobe_cnt - base), 32'd1);
    check("valid_after_frame1", {31'h0, fv[d]}, 32'h1);

    // frames 2 and 3: fixed pattern
    wait_strobe(d, "frame2_strobe");
    exp_q.push_back(p_old);
    wait_strobe(d, "frame3_strobe");

    // frame 4: pattern changes after bit 10; frame 5 shows it
    exp_q.push_back(p_old);
    wait_load(d, 1'b0, "frame4_load_low");
    wait_load(d, 1'b1, "frame4_load_high");
    wait_clk_rises(d, 11, "frame4_bit10");
    pat[d] = p_new;
    check("hold_during_shift", {j1[d], j2[d]}, p_old);
    exp_q.push_back(p_new);
    wait_strobe(d, "frame4_strobe");
    wait_strobe(d, "frame5_strobe");

    // reset at bit 20 aborts the frame
    pat[d] = p_old;
    wait_load(d, 1'b0, "abort_load_low");
    wait_load(d, 1'b1, "abort_load_high");
    wait_clk_rises(d, 20, "abort_bit20");
    rst[d] = 1'b1;
    @(negedge clk);
    check("abort_joysticks", {j1[d], j2[d]}, 32'h0);
    check("abort_frame_valid", {31'h0, fv[d]}, 32'h0);
    check("abort_joy_clk", {31'h0, joy_clk[d]}, 32'h1);
    repeat (3) @(negedge clk);
    pat[d] = p_rst;
    exp_q.push_back(p_rst);
    rst[d] = 1'b0;
    wait_strobe(d, "post_reset_strobe");
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    rst[d] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    pat[0] = 32'h0;
    pat[1] = 32'h0;
    @(negedge clk);
    run_suite(0);
    run_suite(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 100000 clk");
    $fatal(1);
  end

endmodule
